regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
Request-side front end for the register file. It turns a valid/ready request stream (reads and writes) into register file port activity. It absorbs the register file's fixed 1-cycle synchronous read latency and returns read data in order through a buffered valid/ready response port. After every reset, an init sequencer zeroes the low register range before any request is accepted.

Parameters:
DATA_W, 32, data width; matches register file data ports.
ADDR_W, 32, address width; matches register file address ports.
FIFO_DEPTH, 4, response buffer entries; legal range ≥3.
INIT_COUNT, 32, number of registers zeroed after reset (addresses 0..INIT_COUNT-1); 0 disables init.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid & req_ready.
req_write  in  1  1=write, 0=read.
req_addr  in  ADDR_W  register address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  read response present.
rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready.
rsp_data  out  DATA_W  read data, in request order.
busy_init  out  1  init sequencer active.
rf_rd_addr  out  ADDR_W  to register file read address.
rf_wr_addr  out  ADDR_W  to register file write address.
rf_data_in  out  DATA_W  to register file write data.
rf_write_enable  out  1  to register file write enable.
rf_rd_data  in  DATA_W  from register file; valid the cycle after rf_rd_addr is sampled.

Behaviour:
- Reset (async, rst_n=0):
  - State=INIT, init counter=0, pending-read flag=0, FIFO emptied.
  - req_ready=0, rsp_valid=0, rf_write_enable=0.
  - busy_init=1 if INIT_COUNT>0, else 0.
  - All address/data outputs 0.
- Reset mid-operation discards in-flight reads and buffered responses; no response is ever produced for them. Init restarts from address 0.
- FSM has 2 states:
  - INIT:
    - Each cycle drives rf_write_enable=1, rf_wr_addr=counter, rf_data_in=0; counter increments.
    - When counter==INIT_COUNT-1 is written, next state=RUN.
    - INIT_COUNT=0 goes directly to RUN on the first clock after reset release.
    - req_ready=0 and busy_init=1 throughout.
  - RUN: busy_init=0. No exit except reset.
- req_ready (RUN only) = (fifo_count + pending) < FIFO_DEPTH. It does not depend combinationally on rsp_ready or req_valid.
- Write accept: combinationally drives rf_write_enable=1, rf_wr_addr=req_addr, rf_data_in=req_wdata in the same cycle. The register file updates at that edge. A write produces no response.
- Read accept in cycle N:
  - rf_rd_addr=req_addr combinationally.
  - pending set at edge N.
  - In cycle N+1, rf_rd_data is pushed into the FIFO at edge N+1; pending clears unless another read was accepted in N+1.
- rf_rd_addr holds its last value when no read is accepted; rf_rd_data is ignored unless pending=1.
- Write in cycle N followed by a read of the same address in N+1 returns the new data. The register file write lands at edge N, before the read sample at edge N+1, so no bypass is needed.
- Only one request is accepted per cycle, so same-cycle read/write collision cannot occur.
- FIFO:
  - Show-ahead: rsp_valid = count≠0, rsp_data = head.
  - Push and pop in the same cycle keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the req_ready rule. A push when full is a design error; the bench asserts on it.
- Latency: read accept to rsp_valid = 2 cycles when the FIFO is empty.
- Throughput: with rsp_ready held at 1, back-to-back reads sustain 1 per cycle.
- Responses preserve read order regardless of interleaved writes.

Test Plan:
- Reset release with INIT_COUNT=32:
  - busy_init=1 and req_ready=0 for exactly 32 cycles.
  - rf_wr_addr steps 0..31 with data 0.
  - Afterwards, a read of address 5 returns 0.
- Write addr 7=0xDEADBEEF in cycle N, read addr 7 in N+1 → rsp_data=0xDEADBEEF with rsp_valid at N+3.
- Back-to-back reads of addresses 0..7 with rsp_ready=1 → req_ready stays 1 and 8 responses arrive on consecutive cycles, in order.
- Reads with rsp_ready=0 → req_ready drops after 4 accepted reads. When rsp_ready rises, 4 responses drain in order with no loss or duplication.
- Interleaved W(3,0x11), R(3), W(3,0x22), R(3) → responses 0x11 then 0x22.
- rst_n pulsed low while 2 responses are buffered and 1 read is pending → rsp_valid=0 immediately, no stale response appears, and init reruns from address 0.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Request front end for the register file: valid/ready requests in, register file port activity out,
// with read data returned in order through a small show-ahead response FIFO. Zeroes low registers after reset.
module regfile_port_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int INIT_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy_init,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write_enable,
    input  logic [DATA_W-1:0] rf_rd_data
);

    // state   | meaning
    // ST_INIT | zeroing registers 0..INIT_COUNT-1, one per cycle; no requests accepted
    // ST_RUN  | serving requests; left only through reset
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] INIT_LAST = (INIT_COUNT > 0) ? ADDR_W'(INIT_COUNT - 1) : '0;
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                rd_accept;
    logic                wr_accept;
    logic                push;
    logic                pop;
    logic                room;
    logic [CNT_W:0]      occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A read in flight still needs a slot, so it counts against the FIFO space.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
        room      = occupancy < DEPTH_C;
    end

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        busy_init       = 1'b0;
        req_ready       = 1'b0;
        rf_write_enable = 1'b0;
        rf_wr_addr      = '0;
        rf_data_in      = '0;
        rd_accept       = 1'b0;
        wr_accept       = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_COUNT == 0) begin
                    state_d = ST_RUN;
                end else begin
                    busy_init = 1'b1;
                    // Gated by rst_n so no register file write is issued while reset is held.
                    rf_write_enable = rst_n;
                    rf_wr_addr      = init_cnt_q;
                    init_cnt_d      = init_cnt_q + 1'b1;
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                req_ready = room;
                if (req_valid && room) begin
                    if (req_write) begin
                        wr_accept       = 1'b1;
                        rf_write_enable = 1'b1;
                        rf_wr_addr      = req_addr;
                        rf_data_in      = req_wdata;
                    end else begin
                        rd_accept = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        rf_rd_addr = rd_accept ? req_addr : rd_addr_q;
        rd_addr_d  = rf_rd_addr;
        pending_d  = rd_accept;
    end

    // Response FIFO: the register file output is captured the cycle after the read was issued.
    always_comb begin
        push      = pending_q;
        pop       = (count_q != '0) && rsp_ready;
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rsp_valid = (count_q != '0);
        rsp_data  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            pending_q  <= 1'b0;
            rd_addr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            rd_addr_q  <= rd_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= rf_rd_data;
        end
    end

endmodule
